// File: rtl/song_sequencer_if.sv
// Control, ROM-read and note-output signals of the song sequencer, bundled as one port.
// The master modport is the sequencer; the slave modport is the ROM / player side.
interface song_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int DUR_W  = 3
);
    logic                  start;
    logic                  stop;
    logic                  pause;
    logic [1:0]            tempo_sel;
    logic [ADDR_W-1:0]     rom_addr;
    logic [4+DUR_W:0]      rom_data;
    logic [4:0]            note_out;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, stop, pause, tempo_sel, rom_data,
        output rom_addr, note_out, busy, done
    );

    modport slave (
        output start, stop, pause, tempo_sel, rom_data,
        input  rom_addr, note_out, busy, done
    );
endinterface

// File: rtl/song_sequencer.sv
// Autoplay controller: walks a song ROM, holds each note for dur+1 beats, inserts a
// silent gap after every note, and stops at the end marker or the last address.
module song_sequencer #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int ADDR_W      = 6,
    parameter int DUR_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    song_sequencer_if.master bus
);
    localparam int BW = $clog2(BEAT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [BW-1:0]     BEAT_LEN = BW'(BEAT_CYCLES);
    localparam logic [GW-1:0]     GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [4:0]        END_CODE = 5'd31;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, FINISH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [4:0]        note_q, note_d;
    logic [4:0]        note_out_q, note_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BW-1:0]     beat_len_q, beat_len_d;
    logic [BW-1:0]     cyc_q, cyc_d;
    logic [DUR_W-1:0]  beats_left_q, beats_left_d;
    logic [GW-1:0]     gap_q, gap_d;

    logic [4:0]        rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic [BW-1:0]     beat_last;
    logic              frozen;

    assign rom_note  = bus.rom_data[DUR_W+4:DUR_W];
    assign rom_dur   = bus.rom_data[DUR_W-1:0];
    assign beat_last = beat_len_q - BW'(1);
    assign frozen    = bus.pause && (state_q inside {FETCH, LOAD, PLAY, GAP});

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        note_d       = note_q;
        note_out_d   = 5'd0;
        done_d       = 1'b0;
        beat_len_d   = beat_len_q;
        cyc_d        = cyc_q;
        beats_left_d = beats_left_q;
        gap_d        = gap_q;

        if (state_q != IDLE && bus.stop) begin
            state_d      = IDLE;
            rom_addr_d   = '0;
            note_d       = 5'd0;
            cyc_d        = '0;
            beats_left_d = '0;
            gap_d        = '0;
        end else if (!frozen) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_d    = FETCH;
                        rom_addr_d = '0;
                    end
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    if (rom_note == END_CODE) begin
                        state_d = FINISH;
                    end else begin
                        state_d      = PLAY;
                        note_d       = rom_note;
                        note_out_d   = rom_note;
                        beat_len_d   = BEAT_LEN >> bus.tempo_sel;
                        beats_left_d = rom_dur;
                        cyc_d        = '0;
                    end
                end
                PLAY: begin
                    note_out_d = note_q;
                    if (cyc_q == beat_last) begin
                        cyc_d = '0;
                        if (beats_left_q == '0) begin
                            state_d    = GAP;
                            note_out_d = 5'd0;
                            gap_d      = '0;
                        end else begin
                            beats_left_d = beats_left_q - DUR_W'(1);
                        end
                    end else begin
                        cyc_d = cyc_q + BW'(1);
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        if (rom_addr_q == ADDR_MAX) begin
                            state_d = FINISH;
                        end else begin
                            rom_addr_d = rom_addr_q + ADDR_W'(1);
                            state_d    = FETCH;
                        end
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                FINISH: begin
                    // done is raised on leaving FINISH so a stop arriving in FINISH can still cancel it
                    done_d     = 1'b1;
                    rom_addr_d = '0;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rom_addr_q   <= '0;
            note_q       <= 5'd0;
            note_out_q   <= 5'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            beat_len_q   <= '0;
            cyc_q        <= '0;
            beats_left_q <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            note_q       <= note_d;
            note_out_q   <= note_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            beat_len_q   <= beat_len_d;
            cyc_q        <= cyc_d;
            beats_left_q <= beats_left_d;
            gap_q        <= gap_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.note_out = note_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a 4-cycle beat, 2-cycle gap and a 4-entry ROM.
// Cycle index i counts posedges from the one that samples start (i=0), observed 1 time unit later.
module tb_song_sequencer;
    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;
    logic [7:0] rom [4];

    song_sequencer_if #(.ADDR_W(2), .DUR_W(3)) bus ();

    song_sequencer #(
        .BEAT_CYCLES(4),
        .GAP_CYCLES (2),
        .ADDR_W     (2),
        .DUR_W      (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rom(input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        vectors++;
        if (bus.note_out !== 5'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rom_addr !== 2'd0) begin
            errors++;
            $display("FAIL reset_init: note=%0d busy=%b done=%b addr=%0d, want 0/0/0/0",
                     bus.note_out, bus.busy, bus.done, bus.rom_addr);
        end
        rst_n = 1'b1;
        tick();
        load_rom({5'd1, 3'd0}, {5'd8, 3'd1}, {5'd31, 3'd0}, 8'd0);
        pulse_start();
        tick(); tick(); tick();
        vectors++;
        if (bus.note_out !== 5'd1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_play: note=%0d busy=%b, want 1/1", bus.note_out, bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.note_out !== 5'd0 || bus.busy !== 1'b0 || bus.rom_addr !== 2'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: note=%0d busy=%b addr=%0d done=%b, want 0/0/0/0",
                     bus.note_out, bus.busy, bus.rom_addr, bus.done);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.note_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_idle_after: busy=%b note=%0d, want 0/0", bus.busy, bus.note_out);
        end
    endtask

    task automatic test_play();
        logic [4:0] en;
        logic [1:0] ea;
        logic       ed, eb;
        load_rom({5'd1, 3'd0}, {5'd8, 3'd1}, {5'd31, 3'd0}, 8'd0);
        pulse_start();
        for (int i = 0; i <= 24; i++) begin
            if (i > 0) tick();
            en = (i >= 2 && i <= 5) ? 5'd1 : (i >= 10 && i <= 17) ? 5'd8 : 5'd0;
            ea = (i < 8) ? 2'd0 : (i < 20) ? 2'd1 : (i < 23) ? 2'd2 : 2'd0;
            ed = (i == 23);
            eb = (i <= 22);
            vectors++;
            if (bus.note_out !== en || bus.rom_addr !== ea || bus.done !== ed || bus.busy !== eb) begin
                errors++;
                $display("FAIL play cyc %0d: note=%0d addr=%0d done=%b busy=%b, want %0d/%0d/%b/%b",
                         i, bus.note_out, bus.rom_addr, bus.done, bus.busy, en, ea, ed, eb);
            end
        end
    endtask

    task automatic test_pause();
        logic [4:0] en;
        logic [1:0] ea;
        logic       ed, eb;
        load_rom({5'd1, 3'd0}, {5'd8, 3'd1}, {5'd31, 3'd0}, 8'd0);
        pulse_start();
        for (int i = 0; i <= 34; i++) begin
            if (i > 0) tick();
            en = (i >= 2 && i <= 5) ? 5'd1 :
                 ((i >= 10 && i <= 11) || (i >= 22 && i <= 27)) ? 5'd8 : 5'd0;
            ea = (i < 8) ? 2'd0 : (i < 30) ? 2'd1 : (i < 33) ? 2'd2 : 2'd0;
            ed = (i == 33);
            eb = (i <= 32);
            vectors++;
            if (bus.note_out !== en || bus.rom_addr !== ea || bus.done !== ed || bus.busy !== eb) begin
                errors++;
                $display("FAIL pause cyc %0d: note=%0d addr=%0d done=%b busy=%b, want %0d/%0d/%b/%b",
                         i, bus.note_out, bus.rom_addr, bus.done, bus.busy, en, ea, ed, eb);
            end
            bus.pause = (i >= 11 && i < 21);
        end
        bus.pause = 1'b0;
    endtask

    task automatic test_stop();
        logic [4:0] en;
        logic [1:0] ea;
        logic       eb;
        load_rom({5'd1, 3'd0}, {5'd8, 3'd1}, {5'd31, 3'd0}, 8'd0);
        pulse_start();
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) tick();
            en = (i >= 2 && i <= 5) ? 5'd1 : (i >= 10 && i <= 12) ? 5'd8 : 5'd0;
            ea = (i >= 8 && i <= 12) ? 2'd1 : 2'd0;
            eb = (i <= 12);
            vectors++;
            if (bus.note_out !== en || bus.rom_addr !== ea || bus.done !== 1'b0 || bus.busy !== eb) begin
                errors++;
                $display("FAIL stop cyc %0d: note=%0d addr=%0d done=%b busy=%b, want %0d/%0d/0/%b",
                         i, bus.note_out, bus.rom_addr, bus.done, bus.busy, en, ea, eb);
            end
            bus.stop = (i == 12);
        end
        bus.stop = 1'b0;
        pulse_start();
        vectors++;
        if (bus.rom_addr !== 2'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_fetch: addr=%0d busy=%b, want 0/1", bus.rom_addr, bus.busy);
        end
        tick(); tick();
        vectors++;
        if (bus.note_out !== 5'd1) begin
            errors++;
            $display("FAIL restart_note: note=%0d, want 1", bus.note_out);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.note_out !== 5'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL restart_stop: busy=%b note=%0d done=%b, want 0/0/0", bus.busy, bus.note_out, bus.done);
        end
        tick();
    endtask

    task automatic test_tempo();
        logic [4:0] en;
        logic [1:0] ea;
        logic       ed, eb;
        load_rom({5'd3, 3'd2}, {5'd31, 3'd0}, 8'd0, 8'd0);
        bus.tempo_sel = 2'd1;
        pulse_start();
        for (int i = 0; i <= 14; i++) begin
            if (i > 0) tick();
            en = (i >= 2 && i <= 7) ? 5'd3 : 5'd0;
            ea = (i >= 10 && i <= 12) ? 2'd1 : 2'd0;
            ed = (i == 13);
            eb = (i <= 12);
            vectors++;
            if (bus.note_out !== en || bus.rom_addr !== ea || bus.done !== ed || bus.busy !== eb) begin
                errors++;
                $display("FAIL tempo cyc %0d: note=%0d addr=%0d done=%b busy=%b, want %0d/%0d/%b/%b",
                         i, bus.note_out, bus.rom_addr, bus.done, bus.busy, en, ea, ed, eb);
            end
        end
        bus.tempo_sel = 2'd0;
    endtask

    task automatic test_no_marker();
        logic [4:0] notes [4];
        logic [4:0] en;
        logic [1:0] ea;
        logic       ed, eb;
        notes[0] = 5'd2; notes[1] = 5'd4; notes[2] = 5'd6; notes[3] = 5'd7;
        load_rom({5'd2, 3'd0}, {5'd4, 3'd0}, {5'd6, 3'd0}, {5'd7, 3'd0});
        pulse_start();
        for (int i = 0; i <= 35; i++) begin
            if (i > 0) tick();
            en = (i >= 2 && i <= 29 && ((i - 2) % 8) < 4) ? notes[(i - 2) / 8] : 5'd0;
            ea = (i < 8) ? 2'd0 : (i < 16) ? 2'd1 : (i < 24) ? 2'd2 : (i < 33) ? 2'd3 : 2'd0;
            ed = (i == 33);
            eb = (i <= 32);
            vectors++;
            if (bus.note_out !== en || bus.rom_addr !== ea || bus.done !== ed || bus.busy !== eb) begin
                errors++;
                $display("FAIL nomarker cyc %0d: note=%0d addr=%0d done=%b busy=%b, want %0d/%0d/%b/%b",
                         i, bus.note_out, bus.rom_addr, bus.done, bus.busy, en, ea, ed, eb);
            end
        end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.busy !== 1'b0 || bus.rom_addr !== 2'd0 || bus.note_out !== 5'd0) begin
                errors++;
                $display("FAIL start_stop_idle cyc %0d: busy=%b addr=%0d note=%0d, want 0/0/0",
                         i, bus.busy, bus.rom_addr, bus.note_out);
            end
            tick();
        end
    endtask

    initial begin
        vectors       = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.pause     = 1'b0;
        bus.tempo_sel = 2'd0;
        load_rom(8'd0, 8'd0, 8'd0, 8'd0);
        test_reset();
        test_play();
        tick();
        test_pause();
        tick();
        test_stop();
        test_tempo();
        tick();
        test_no_marker();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
